regfile_wb_checker: RTL and testbench
=====================================

// Module: regfile_wb_checker
// PURPOSE
//   Synthesizable, parametrised writeback checker. It replaces end-of-run ad hoc register peeks in processor benches.
//   Taps the register-file write ports: wa3/wd3 and, for long multiply, wa3_2/wd3_2.
//   Keeps a shadow copy of the architectural registers and checks it against a table of expected (register, value) slots.
//   Reports PASS, FAIL on a write-port conflict, or TIMEOUT, together with cycle count and failure details.
// PARAMETERS
//   NREGS        15    shadowed registers R0..NREGS-1; writes to higher addresses (e.g. PC) are ignored
//   DW           32    register data width
//   AW           4     register address width
//   NWP          2     number of write ports observed
//   NCHK         8     number of expected-value slots
//   TIMEOUT      2500  RUN cycles before the run is declared TIMEOUT
//   TRACE_DEPTH  16    trace buffer entries (WBCHK_TRACE_EN only); power of two
// PORTS
//   clk           in   1           single clock; everything updates on the rising edge
//   reset         in   1           asynchronous, active-high; clears all state
//   start         in   1           1-cycle pulse: arm or re-arm the run
//   we            in   NWP         per-port write enable
//   wa            in   NWP*AW      per-port write address; port p is wa[p*AW +: AW]
//   wd            in   NWP*DW      per-port write data
//   chk_vld       in   NCHK        slot enable; held static during RUN
//   chk_reg       in   NCHK*AW     expected register index per slot
//   chk_val       in   NCHK*DW     expected value per slot
//   busy          out  1           state == RUN
//   pass          out  1           state == PASS
//   fail          out  1           state == FAIL or state == TIMEOUT
//   fail_code     out  2           0 none, 1 port conflict, 2 timeout
//   fail_idx      out  clog2(NCHK) lowest mismatching slot (timeout); 0 otherwise
//   fail_got      out  DW          shadow value of slot fail_idx at timeout
//   cycle_cnt     out  32          RUN cycles elapsed; frozen in terminal states
//   trace_idx     in   clog2(TRACE_DEPTH) trace read index; 0 = newest entry
//   trace_addr    out  AW          trace entry address (combinational read)
//   trace_data    out  DW          trace entry data
//   trace_cyc     out  32          cycle_cnt value when the entry was written
//   trace_cnt     out  clog2(TRACE_DEPTH)+1 valid entries, saturates at TRACE_DEPTH
// BEHAVIOUR
//   Reset values: all outputs 0, shadow registers 0, state IDLE.
//   States: IDLE -> RUN on start.
//     PASS, FAIL and TIMEOUT are terminal.
//     start in a terminal state -> RUN; clears cycle_cnt and fail_*; the shadow is kept.
//     start while in RUN is ignored.
//   RUN, every edge:
//     - Update the shadow from every port with we=1 and wa<NREGS.
//     - cycle_cnt increments by 1.
//   Conflict: two ports enabled with the same wa in the same cycle.
//     -> FAIL, fail_code=1. The higher-index port's data lands in the shadow.
//   allmatch: combinational from the registered shadow. True when every enabled slot has shadow[chk_reg]==chk_val.
//     Slots with chk_reg>=NREGS never match.
//     No enabled slots -> allmatch is true, so the first RUN cycle goes to PASS.
//   Latency: a completing write sampled at edge E is in the shadow after E; pass rises after edge E+1.
//   Timeout: cycle_cnt==TIMEOUT-1 in RUN with !allmatch -> TIMEOUT, fail_code=2.
//     fail_idx = lowest enabled mismatching slot; fail_got = its shadow value.
//   Priority within one cycle: conflict > allmatch > timeout.
//   Reset mid-run: returns to IDLE immediately (asynchronous), and the shadow is cleared.
// CONFIGURATION
//   WBCHK_TRACE_EN defined: a circular trace records every accepted write (we=1, wa<NREGS) in RUN.
//     Simultaneous writes are stored in port order, lowest port first.
//     When full, the oldest entry is overwritten.
//     trace_cnt saturates at TRACE_DEPTH and is cleared by start.
//   WBCHK_TRACE_EN undefined: trace_* outputs tied to 0 and no trace storage is built.
// STRUCTURE
//   Package wbchk_pkg:
//     - wbchk_state_t {IDLE, RUN, PASS, FAIL, TIMEOUT}
//     - fail codes FC_NONE, FC_CONFLICT, FC_TIMEOUT
//     - clog2 helper function
//   Sub-module wb_trace_buf, instantiated only under WBCHK_TRACE_EN:
//     - NWP-wide write, single combinational read port
//     - write pointer and count
//   Top level: shadow array, conflict detector, match/priority logic, FSM, cycle counter.
// TESTING
//   1. Slot0 = (R0, 10). start, then port0 writes R0=10 -> pass after 2 edges; cycle_cnt frozen; fail_code=0.
//   2. Same cycle: port0 R3=5 and port1 R3=7 -> FAIL, fail_code=1, shadow R3=7; a later matching write does not produce pass.
//   3. TIMEOUT=20, slots R1=4 and R2=9, only R1=4 written -> at cycle 19 TIMEOUT, fail_idx=1, fail_got=0.
//   4. Long-mul pair: port0 R4=0xDEADBEEF and port1 R5=0x1 in one cycle, slots R4 and R5 -> PASS; writes to wa=15 ignored.
//   5. Assert reset mid-RUN at cycle 7, then start -> busy, cycle_cnt restarts at 0, shadow all 0.
//   6. (WBCHK_TRACE_EN, TRACE_DEPTH=4) six single writes R0..R5=v0..v5 -> trace_cnt=4; idx0=R5/v5, idx3=R2/v2; trace_cyc correct.

Source files
------------

// File: rtl/wbchk_pkg.sv
// Shared types and helpers for the register-file writeback checker.
//   wbchk_state_t : checker run state
//   FC_*          : fail_code encodings
//   clog2         : ceiling log2, used for index and counter widths
package wbchk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } wbchk_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_CONFLICT = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_trace_buf.sv
// Circular trace of accepted register writes (built only with WBCHK_TRACE_EN).
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   clr         : empties the buffer (a new run was armed)
//   wen         : per-port accepted-write strobe
//   waddr/wdata : per-port address and data, port p at slice p
//   wcyc        : cycle stamp stored with each entry
//   ridx        : read index, 0 = newest entry
//   raddr/rdata/rcyc : combinational read of entry ridx
//   cnt         : number of valid entries, saturating at DEPTH
module wb_trace_buf
    import wbchk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NWP   = 2,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [NWP-1:0]           wen,
    input  logic [NWP*AW-1:0]        waddr,
    input  logic [NWP*DW-1:0]        wdata,
    input  logic [31:0]              wcyc,
    input  logic [clog2(DEPTH)-1:0]  ridx,
    output logic [AW-1:0]            raddr,
    output logic [DW-1:0]            rdata,
    output logic [31:0]              rcyc,
    output logic [clog2(DEPTH):0]    cnt
);

    localparam int PW = clog2(DEPTH);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [31:0]   mem_cyc  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] slot [NWP];
    logic [PW:0]   n_new;
    logic [PW+1:0] cnt_sum;
    logic [PW-1:0] rd_ptr;

    // Simultaneous writes take consecutive slots in port order, so each
    // port's slot is the write pointer plus the number of lower ports writing.
    always_comb begin
        n_new = '0;
        for (int p = 0; p < NWP; p++) begin
            slot[p] = wr_ptr + n_new[PW-1:0];
            if (wen[p]) n_new = n_new + (PW+1)'(1);
        end
        cnt_sum = {1'b0, cnt} + {1'b0, n_new};
    end

    // Storage, pointer and saturating count. The oldest entry is simply
    // overwritten once the pointer wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
                mem_cyc[i]  <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (wen[p]) begin
                    mem_addr[slot[p]] <= waddr[p*AW +: AW];
                    mem_data[slot[p]] <= wdata[p*DW +: DW];
                    mem_cyc[slot[p]]  <= wcyc;
                end
            end
            wr_ptr <= wr_ptr + n_new[PW-1:0];
            cnt    <= (cnt_sum > (PW+2)'(DEPTH)) ? (PW+1)'(DEPTH) : cnt_sum[PW:0];
        end
    end

    assign rd_ptr = wr_ptr - PW'(1) - ridx;
    assign raddr  = mem_addr[rd_ptr];
    assign rdata  = mem_data[rd_ptr];
    assign rcyc   = mem_cyc[rd_ptr];

endmodule

// File: rtl/regfile_wb_checker.sv
// Writeback checker: shadows the architectural registers from the register-file
// write ports and compares them against a table of expected (register, value)
// slots, ending in PASS, FAIL (write-port conflict) or TIMEOUT.
// Optional feature: define WBCHK_TRACE_EN to build a circular trace of accepted
// writes; otherwise the trace_* outputs are tied to zero.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : pulse to arm / re-arm a run (ignored while busy)
//   we/wa/wd          : observed write ports, port p at slice p
//   chk_vld/reg/val   : expected-value slots
//   busy/pass/fail    : run status
//   fail_code/idx/got : failure cause, first mismatching slot and its shadow value
//   cycle_cnt         : RUN cycles elapsed
//   trace_idx, trace_addr/data/cyc/cnt : trace read port
module regfile_wb_checker
    import wbchk_pkg::*;
#(
    parameter int NREGS       = 15,
    parameter int DW          = 32,
    parameter int AW          = 4,
    parameter int NWP         = 2,
    parameter int NCHK        = 8,
    parameter int TIMEOUT     = 2500,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NWP-1:0]                 we,
    input  logic [NWP*AW-1:0]              wa,
    input  logic [NWP*DW-1:0]              wd,
    input  logic [NCHK-1:0]                chk_vld,
    input  logic [NCHK*AW-1:0]             chk_reg,
    input  logic [NCHK*DW-1:0]             chk_val,
    output logic                           busy,
    output logic                           pass,
    output logic                           fail,
    output logic [1:0]                     fail_code,
    output logic [clog2(NCHK)-1:0]         fail_idx,
    output logic [DW-1:0]                  fail_got,
    output logic [31:0]                    cycle_cnt,
    input  logic [clog2(TRACE_DEPTH)-1:0]  trace_idx,
    output logic [AW-1:0]                  trace_addr,
    output logic [DW-1:0]                  trace_data,
    output logic [31:0]                    trace_cyc,
    output logic [clog2(TRACE_DEPTH):0]    trace_cnt
);

    localparam int IW = clog2(NCHK);

    wbchk_state_t  state;
    logic [DW-1:0] shadow [NREGS];
    logic [NWP-1:0] acc;
    logic          conflict;
    logic          allmatch;
    logic          miss_found;
    logic [IW-1:0] miss_idx;
    logic [DW-1:0] miss_val;
    logic [AW-1:0] slot_reg;
    logic [DW-1:0] slot_got;

    // A write is accepted only for shadowed registers; writes to higher
    // addresses such as the PC are dropped. A conflict is any two enabled
    // ports naming the same address, whether or not it is shadowed.
    always_comb begin
        acc      = '0;
        conflict = 1'b0;
        for (int p = 0; p < NWP; p++) begin
            acc[p] = we[p] && (32'(wa[p*AW +: AW]) < 32'(NREGS));
            for (int q = p + 1; q < NWP; q++) begin
                if (we[p] && we[q] && (wa[p*AW +: AW] == wa[q*AW +: AW]))
                    conflict = 1'b1;
            end
        end
    end

    // Compare every enabled slot against the registered shadow and remember
    // the lowest mismatching one for the timeout report. Slots naming an
    // unshadowed register can never match.
    always_comb begin
        allmatch   = 1'b1;
        miss_found = 1'b0;
        miss_idx   = '0;
        miss_val   = '0;
        slot_reg   = '0;
        slot_got   = '0;
        for (int s = 0; s < NCHK; s++) begin
            slot_reg = chk_reg[s*AW +: AW];
            slot_got = (32'(slot_reg) < 32'(NREGS)) ? shadow[slot_reg] : '0;
            if (chk_vld[s] && ((32'(slot_reg) >= 32'(NREGS)) ||
                               (slot_got != chk_val[s*DW +: DW]))) begin
                allmatch = 1'b0;
                if (!miss_found) begin
                    miss_found = 1'b1;
                    miss_idx   = IW'(s);
                    miss_val   = slot_got;
                end
            end
        end
    end

    // Shadow update while running. Ports are applied lowest first so that on
    // a conflict the highest-index port's data is the one that sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) shadow[r] <= '0;
        end else if (state == ST_RUN) begin
            for (int p = 0; p < NWP; p++) begin
                if (acc[p]) shadow[wa[p*AW +: AW]] <= wd[p*DW +: DW];
            end
        end
    end

    // Run FSM with cycle counter and failure report. Priority on the exit
    // edge is conflict, then match, then timeout; the counter still ticks on
    // that edge and is then frozen until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cycle_cnt <= '0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_got  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (conflict) begin
                        state     <= ST_FAIL;
                        fail_code <= FC_CONFLICT;
                    end else if (allmatch) begin
                        state <= ST_PASS;
                    end else if (cycle_cnt == 32'(TIMEOUT - 1)) begin
                        state     <= ST_TIMEOUT;
                        fail_code <= FC_TIMEOUT;
                        fail_idx  <= miss_idx;
                        fail_got  <= miss_val;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= ST_RUN;
                        cycle_cnt <= '0;
                        fail_code <= FC_NONE;
                        fail_idx  <= '0;
                        fail_got  <= '0;
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL) || (state == ST_TIMEOUT);

`ifdef WBCHK_TRACE_EN
    logic           trace_clr;
    logic [NWP-1:0] trace_wen;

    // The trace is emptied whenever a start is actually accepted.
    assign trace_clr = start && (state != ST_RUN);
    assign trace_wen = acc & {NWP{state == ST_RUN}};

    wb_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .NWP   (NWP),
        .AW    (AW),
        .DW    (DW)
    ) u_trace (
        .clk   (clk),
        .reset (reset),
        .clr   (trace_clr),
        .wen   (trace_wen),
        .waddr (wa),
        .wdata (wd),
        .wcyc  (cycle_cnt),
        .ridx  (trace_idx),
        .raddr (trace_addr),
        .rdata (trace_data),
        .rcyc  (trace_cyc),
        .cnt   (trace_cnt)
    );
`else
    logic unused_trace;

    assign unused_trace = ^trace_idx;
    assign trace_addr   = '0;
    assign trace_data   = '0;
    assign trace_cyc    = '0;
    assign trace_cnt    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_checker.sv
// Self-checking bench for regfile_wb_checker: directed vector table, hand-written
// corner sequences and randomized runs, all compared against a behavioural model.
module tb_regfile_wb_checker;

    localparam int NREGS = 15;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NWP   = 2;
    localparam int NCHK  = 8;
    localparam int TMO   = 20;
    localparam int TD    = 4;
    localparam int IW    = 3;
    localparam int TW    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NWP-1:0]    we;
    logic [NWP*AW-1:0] wa;
    logic [NWP*DW-1:0] wd;
    logic [NCHK-1:0]   chk_vld;
    logic [NCHK*AW-1:0] chk_reg;
    logic [NCHK*DW-1:0] chk_val;
    logic              busy, pass, fail;
    logic [1:0]        fail_code;
    logic [IW-1:0]     fail_idx;
    logic [DW-1:0]     fail_got;
    logic [31:0]       cycle_cnt;
    logic [TW-1:0]     trace_idx;
    logic [AW-1:0]     trace_addr;
    logic [DW-1:0]     trace_data;
    logic [31:0]       trace_cyc;
    logic [TW:0]       trace_cnt;

    int checks = 0;
    int errors = 0;

    regfile_wb_checker #(
        .NREGS(NREGS), .DW(DW), .AW(AW), .NWP(NWP), .NCHK(NCHK),
        .TIMEOUT(TMO), .TRACE_DEPTH(TD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .wa(wa), .wd(wd),
        .chk_vld(chk_vld), .chk_reg(chk_reg), .chk_val(chk_val),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_idx(fail_idx), .fail_got(fail_got), .cycle_cnt(cycle_cnt),
        .trace_idx(trace_idx), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_cyc(trace_cyc), .trace_cnt(trace_cnt)
    );

    always #10 clk = ~clk;

    // Behavioural model: what the checker should report, derived from the run rules.
    typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TMO} mstate_t;
    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } tr_t;

    mstate_t     m_st;
    logic [31:0] m_sh [NREGS];
    int          m_cyc, m_code, m_idx;
    logic [31:0] m_got;
    tr_t         m_tr [$];

    task automatic modelReset();
        m_st = M_IDLE;
        m_cyc = 0; m_code = 0; m_idx = 0; m_got = 0;
        for (int r = 0; r < NREGS; r++) m_sh[r] = 0;
        m_tr.delete();
    endtask

    task automatic modelStep();
        bit conflict, match, found;
        int first, r, a, b;
        logic [31:0] first_v, got;
        tr_t e;
        if (m_st != M_RUN) begin
            if (start) begin
                m_st = M_RUN; m_cyc = 0; m_code = 0; m_idx = 0; m_got = 0;
                m_tr.delete();
            end
            return;
        end
        match = 1; found = 0; first = 0; first_v = 0; conflict = 0;
        for (int s = 0; s < NCHK; s++) begin
            if (chk_vld[s]) begin
                r = int'(chk_reg[s*AW +: AW]);
                got = (r < NREGS) ? m_sh[r] : 32'd0;
                if (r >= NREGS || got != chk_val[s*DW +: DW]) begin
                    match = 0;
                    if (!found) begin found = 1; first = s; first_v = got; end
                end
            end
        end
        a = int'(wa[AW-1:0]);
        b = int'(wa[2*AW-1:AW]);
        if (we[0] && we[1] && a == b) conflict = 1;
        for (int p = 0; p < NWP; p++) begin
            r = int'(wa[p*AW +: AW]);
            if (we[p] && r < NREGS) begin
`ifdef WBCHK_TRACE_EN
                e.a = r; e.d = wd[p*DW +: DW]; e.c = m_cyc;
                m_tr.push_front(e);
                if (m_tr.size() > TD) void'(m_tr.pop_back());
`endif
                m_sh[r] = wd[p*DW +: DW];
            end
        end
        if (conflict) begin
            m_st = M_FAIL; m_code = 1;
        end else if (match) begin
            m_st = M_PASS;
        end else if (m_cyc == TMO - 1) begin
            m_st = M_TMO; m_code = 2; m_idx = first; m_got = first_v;
        end
        m_cyc = m_cyc + 1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 64'(m_st == M_RUN));
        checkOutput({tag, ".pass"}, 64'(pass), 64'(m_st == M_PASS));
        checkOutput({tag, ".fail"}, 64'(fail), 64'(m_st == M_FAIL || m_st == M_TMO));
        checkOutput({tag, ".fail_code"}, 64'(fail_code), 64'(m_code));
        checkOutput({tag, ".fail_idx"}, 64'(fail_idx), 64'(m_idx));
        checkOutput({tag, ".fail_got"}, 64'(fail_got), 64'(m_got));
        checkOutput({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(m_cyc));
`ifdef WBCHK_TRACE_EN
        checkOutput({tag, ".trace_cnt"}, 64'(trace_cnt), 64'(m_tr.size()));
        for (int i = 0; i < m_tr.size(); i++) begin
            trace_idx = TW'(i);
            #1;
            checkOutput($sformatf("%s.trace_addr[%0d]", tag, i), 64'(trace_addr), 64'(m_tr[i].a));
            checkOutput($sformatf("%s.trace_data[%0d]", tag, i), 64'(trace_data), 64'(m_tr[i].d));
            checkOutput($sformatf("%s.trace_cyc[%0d]", tag, i), 64'(trace_cyc), 64'(m_tr[i].c));
        end
`else
        trace_idx = TW'($urandom_range(0, TD - 1));
        #1;
        checkOutput({tag, ".trace_cnt"}, 64'(trace_cnt), 64'd0);
        checkOutput({tag, ".trace_addr"}, 64'(trace_addr), 64'd0);
        checkOutput({tag, ".trace_data"}, 64'(trace_data), 64'd0);
        checkOutput({tag, ".trace_cyc"}, 64'(trace_cyc), 64'd0);
`endif
    endtask

    task automatic setSlot(input int s, input bit v, input int r, input logic [31:0] val);
        chk_vld[s] = v;
        chk_reg[s*AW +: AW] = AW'(r);
        chk_val[s*DW +: DW] = val;
    endtask

    task automatic clearSlots();
        chk_vld = '0; chk_reg = '0; chk_val = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // return #1 after the edge with the write ports released.
    task automatic applyStimulus(input bit st, input int w, input int a0, input logic [31:0] d0,
                                 input int a1, input logic [31:0] d1);
        start = st;
        we = NWP'(w);
        wa = {AW'(a1), AW'(a0)};
        wd = {d1, d0};
        modelStep();
        @(posedge clk);
        #1;
        start = 1'b0;
        we = '0;
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        modelReset();
    endtask

    typedef struct {
        int st, w, a0, d0, a1, d1, s_reg, s_val;
        int e_busy, e_pass, e_fail, e_code, e_cyc;
    } vec_t;

    vec_t vecs [9];
    int   wait_cnt;

    initial begin
        reset = 1'b1; start = 1'b0; we = '0; wa = '0; wd = '0; trace_idx = '0;
        clearSlots();
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.pass", 64'(pass), 64'd0);
        checkOutput("reset.fail", 64'(fail), 64'd0);
        checkOutput("reset.cycle_cnt", 64'(cycle_cnt), 64'd0);
        checkModel("reset");

        // Directed table: single-write pass, then conflict fail and re-arm.
        vecs = '{
            '{1, 0, 0, 0,  0, 0, 0, 10, 1, 0, 0, 0, 0},
            '{0, 1, 0, 10, 0, 0, 0, 10, 1, 0, 0, 0, 1},
            '{0, 0, 0, 0,  0, 0, 0, 10, 0, 1, 0, 0, 2},
            '{0, 0, 0, 0,  0, 0, 0, 10, 0, 1, 0, 0, 2},
            '{1, 0, 0, 0,  0, 0, 3, 5,  1, 0, 0, 0, 0},
            '{0, 3, 3, 5,  3, 7, 3, 5,  0, 0, 1, 1, 1},
            '{0, 1, 3, 5,  0, 0, 3, 5,  0, 0, 1, 1, 1},
            '{1, 0, 0, 0,  0, 0, 3, 7,  1, 0, 0, 0, 0},
            '{0, 0, 0, 0,  0, 0, 3, 7,  0, 1, 0, 0, 1}
        };
        for (int i = 0; i < 9; i++) begin
            clearSlots();
            setSlot(0, 1'b1, vecs[i].s_reg, 32'(vecs[i].s_val));
            applyStimulus(vecs[i].st[0], vecs[i].w, vecs[i].a0, 32'(vecs[i].d0),
                          vecs[i].a1, 32'(vecs[i].d1));
            checkOutput($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d.pass", i), 64'(pass), 64'(vecs[i].e_pass));
            checkOutput($sformatf("vec%0d.fail", i), 64'(fail), 64'(vecs[i].e_fail));
            checkOutput($sformatf("vec%0d.code", i), 64'(fail_code), 64'(vecs[i].e_code));
            checkOutput($sformatf("vec%0d.cyc", i), 64'(cycle_cnt), 64'(vecs[i].e_cyc));
            checkModel($sformatf("vec%0d", i));
        end

        // Timeout with one slot unsatisfied
        doReset();
        clearSlots();
        setSlot(0, 1'b1, 1, 32'd4);
        setSlot(1, 1'b1, 2, 32'd9);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'd4, 0, 0);
        wait_cnt = 0;
        while (!fail && wait_cnt < 40) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkModel("tmo");
            wait_cnt++;
        end
        checkOutput("tmo.fail", 64'(fail), 64'd1);
        checkOutput("tmo.code", 64'(fail_code), 64'd2);
        checkOutput("tmo.idx", 64'(fail_idx), 64'd1);
        checkOutput("tmo.got", 64'(fail_got), 64'd0);
        checkOutput("tmo.cyc", 64'(cycle_cnt), 64'(TMO));

        // Long-multiply pair plus an ignored write to the PC
        doReset();
        clearSlots();
        setSlot(0, 1'b1, 4, 32'hDEADBEEF);
        setSlot(1, 1'b1, 5, 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 15, 32'hDEADBEEF, 0, 0);
        checkModel("lmul.pc");
        checkOutput("lmul.pc_busy", 64'(busy), 64'd1);
        applyStimulus(0, 3, 4, 32'hDEADBEEF, 5, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("lmul.pass", 64'(pass), 64'd1);
        checkOutput("lmul.code", 64'(fail_code), 64'd0);
        checkModel("lmul");

        // A slot naming an unshadowed register never matches
        clearSlots();
        setSlot(0, 1'b1, 15, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        wait_cnt = 0;
        while (!fail && wait_cnt < 40) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            wait_cnt++;
        end
        checkOutput("r15.code", 64'(fail_code), 64'd2);
        checkOutput("r15.idx", 64'(fail_idx), 64'd0);
        checkModel("r15");

        // No enabled slots: first RUN edge passes
        clearSlots();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("empty.pass", 64'(pass), 64'd1);
        checkOutput("empty.cyc", 64'(cycle_cnt), 64'd1);

        // Reset in the middle of a run
        doReset();
        clearSlots();
        setSlot(0, 1'b1, 6, 32'd99);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'd3, 0, 0);
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midrst.cyc7", 64'(cycle_cnt), 64'd7);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst.busy", 64'(busy), 64'd0);
        checkOutput("midrst.cyc", 64'(cycle_cnt), 64'd0);
        reset = 1'b0;
        modelReset();
        clearSlots();
        for (int s = 0; s < NCHK; s++) setSlot(s, 1'b1, s, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("midrst.rebusy", 64'(busy), 64'd1);
        checkOutput("midrst.recyc", 64'(cycle_cnt), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midrst.zero_shadow", 64'(pass), 64'd1);
        checkModel("midrst");

        // Six single writes into a four-entry trace
        doReset();
        clearSlots();
        setSlot(0, 1'b1, 14, 32'h1234);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, k, 32'hA0 + 32'(k), 0, 0);
        checkModel("trace");
`ifdef WBCHK_TRACE_EN
        checkOutput("trace.cnt", 64'(trace_cnt), 64'd4);
        trace_idx = 2'd0;
        #1;
        checkOutput("trace.idx0_addr", 64'(trace_addr), 64'd5);
        checkOutput("trace.idx0_data", 64'(trace_data), 64'hA5);
        checkOutput("trace.idx0_cyc", 64'(trace_cyc), 64'd5);
        trace_idx = 2'd3;
        #1;
        checkOutput("trace.idx3_addr", 64'(trace_addr), 64'd2);
        checkOutput("trace.idx3_data", 64'(trace_data), 64'hA2);
        checkOutput("trace.idx3_cyc", 64'(trace_cyc), 64'd2);
`else
        checkOutput("trace.cnt_off", 64'(trace_cnt), 64'd0);
`endif

        // Randomized runs against the model
        doReset();
        for (int ep = 0; ep < 30; ep++) begin
            int a0, a1, n;
            clearSlots();
            n = $urandom_range(0, 3);
            for (int s = 0; s < n; s++)
                setSlot(s, 1'b1, $urandom_range(0, 15), 32'($urandom_range(0, 3)));
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkModel($sformatf("rnd%0d.start", ep));
            for (int c = 0; c < 30 && m_st == M_RUN; c++) begin
                a0 = $urandom_range(0, 15);
                a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 15);
                applyStimulus(($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                              a0, 32'($urandom_range(0, 3)), a1, 32'($urandom_range(0, 3)));
                checkModel($sformatf("rnd%0d.c%0d", ep, c));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
